// File: rtl/mux8_sel_sequencer.sv
// Byte-to-serial front end for an 8:1 mux: latches a byte on a valid/ready
// handshake and steps sel through all eight positions, HOLD_CYCLES clocks each.
module mux8_sel_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] a,
  output logic [2:0] sel,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [2:0]    bcnt, bcnt_n, sel_n;
  logic [7:0]    a_n;
  logic          run, hold_end, last, accept;

  // bcnt always counts upward; only the presented select is mirrored.
  function automatic logic [2:0] order(input logic [2:0] b);
    return MSB_FIRST ? (3'd7 - b) : b;
  endfunction

  assign run         = (state == RUN);
  assign hold_end    = (hcnt == HMAX);
  assign last        = run && (bcnt == 3'd7) && hold_end;
  assign in_ready    = !run || last;
  assign accept      = in_valid && in_ready;
  assign bit_valid   = run;
  assign busy        = run;
  assign frame_start = run && (bcnt == 3'd0) && (hcnt == '0);
  assign frame_done  = last;

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    bcnt_n  = bcnt;
    sel_n   = sel;
    a_n     = a;
    if (accept) begin
      state_n = RUN;
      a_n     = in_data;
      hcnt_n  = '0;
      bcnt_n  = 3'd0;
      sel_n   = order(3'd0);
    end else if (run) begin
      if (last) begin
        state_n = IDLE;
        hcnt_n  = '0;
      end else if (hold_end) begin
        hcnt_n = '0;
        bcnt_n = bcnt + 3'd1;
        sel_n  = order(bcnt + 3'd1);
      end else begin
        hcnt_n = hcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      bcnt  <= 3'd0;
      sel   <= 3'd0;
      a     <= 8'h00;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      bcnt  <= bcnt_n;
      sel   <= sel_n;
      a     <= a_n;
    end
  end

endmodule

// File: tb/tb_mux8_sel_sequencer.sv
// Scoreboard bench: three sequencer variants (LSB-first/4, MSB-first/4, LSB-first/1)
// share clock, reset and data; per-cycle expectations are queued at each accept.
module tb_mux8_sel_sequencer;

  typedef struct {
    logic [7:0] a;
    logic [2:0] sel;
    logic       z;
    logic       fs;
    logic       fd;
  } entry_t;

  logic       clk;
  logic       rst;
  logic [2:0] iv;
  logic [7:0] in_data;

  logic [7:0] a_o   [3];
  logic [2:0] sel_o [3];
  logic [2:0] rdy_o, bv_o, fs_o, fd_o, busy_o;

  entry_t     sb[$];
  int         cur;
  int         checks;
  int         errors;
  int         acc_cnt;
  bit         mon_en;
  bit         exp_ready;
  logic [7:0] last_a;
  logic [2:0] last_sel;

  mux8_sel_sequencer #(.HOLD_CYCLES(4), .MSB_FIRST(1'b0)) u_lsb4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(in_data), .in_ready(rdy_o[0]),
    .a(a_o[0]), .sel(sel_o[0]), .bit_valid(bv_o[0]), .frame_start(fs_o[0]),
    .frame_done(fd_o[0]), .busy(busy_o[0]));

  mux8_sel_sequencer #(.HOLD_CYCLES(4), .MSB_FIRST(1'b1)) u_msb4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(in_data), .in_ready(rdy_o[1]),
    .a(a_o[1]), .sel(sel_o[1]), .bit_valid(bv_o[1]), .frame_start(fs_o[1]),
    .frame_done(fd_o[1]), .busy(busy_o[1]));

  mux8_sel_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) u_lsb1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(in_data), .in_ready(rdy_o[2]),
    .a(a_o[2]), .sel(sel_o[2]), .bit_valid(bv_o[2]), .frame_start(fs_o[2]),
    .frame_done(fd_o[2]), .busy(busy_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hold_of(input int n);
    return (n == 2) ? 1 : 4;
  endfunction

  function automatic bit msb_of(input int n);
    return (n == 1);
  endfunction

  task automatic checkOutput(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Negedge compares the live instance against the queue; posedge models accept/reset.
  always begin
    entry_t     e;
    logic [7:0] av;
    logic [2:0] sv;
    @(negedge clk);
    if (mon_en) begin
      av = a_o[cur];
      sv = sel_o[cur];
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("a", av, e.a);
        checkOutput("sel", sv, e.sel);
        checkOutput("z", av[sv], e.z);
        checkOutput("bit_valid", bv_o[cur], 1);
        checkOutput("busy", busy_o[cur], 1);
        checkOutput("frame_start", fs_o[cur], e.fs);
        checkOutput("frame_done", fd_o[cur], e.fd);
        checkOutput("in_ready_run", rdy_o[cur], e.fd);
        last_a    = e.a;
        last_sel  = e.sel;
        exp_ready = e.fd;
      end else begin
        checkOutput("idle_a", av, last_a);
        checkOutput("idle_sel", sv, last_sel);
        checkOutput("idle_bit_valid", bv_o[cur], 0);
        checkOutput("idle_busy", busy_o[cur], 0);
        checkOutput("idle_frame_start", fs_o[cur], 0);
        checkOutput("idle_frame_done", fd_o[cur], 0);
        checkOutput("idle_in_ready", rdy_o[cur], 1);
        exp_ready = 1'b1;
      end
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      last_a    = 8'h00;
      last_sel  = 3'd0;
      exp_ready = 1'b1;
    end else if (iv[cur] && exp_ready) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < hold_of(cur); j++) begin
          e.a   = in_data;
          e.sel = msb_of(cur) ? 3'(7 - i) : 3'(i);
          e.z   = in_data[e.sel];
          e.fs  = (i == 0) && (j == 0);
          e.fd  = (i == 7) && (j == hold_of(cur) - 1);
          sb.push_back(e);
        end
      end
      acc_cnt++;
    end
  end

  // Callers are always at posedge+1; returns at posedge+1 after the byte is taken.
  task automatic applyStimulus(input logic [7:0] b, input bit keep);
    int n;
    bit got;
    n       = acc_cnt;
    got     = 1'b0;
    in_data = b;
    iv[cur] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != n) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    if (!keep) iv[cur] = 1'b0;
  endtask

  task automatic waitIdle(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input int n);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cur = n;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    acc_cnt   = 0;
    mon_en    = 1'b0;
    exp_ready = 1'b1;
    last_a    = 8'h00;
    last_sel  = 3'd0;
    cur       = 0;
    rst       = 1'b1;
    iv        = 3'b111;
    in_data   = 8'hA5;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    iv  = 3'b000;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] single frame, LSB-first");
    applyStimulus(8'b00001111, 1'b0);
    waitIdle(100);

    $display("[TB] MSB-first order");
    resetDut(1);
    applyStimulus(8'b11001111, 1'b0);
    waitIdle(100);

    $display("[TB] back-to-back frames");
    resetDut(0);
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'hF0, 1'b0);
    waitIdle(100);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hFF, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    resetDut(0);
    applyStimulus(8'h6F, 1'b0);
    waitIdle(100);

    $display("[TB] HOLD_CYCLES=1");
    resetDut(2);
    applyStimulus(8'h4F, 1'b0);
    waitIdle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux8_sel_sequencer.md
# mux8_sel_sequencer

Upstream driver for the 8:1 mux datapath (`Mux8_v`). It accepts one byte over a valid/ready handshake and presents it on the mux data input `a`. It then steps the mux select `sel` through all eight positions, holding each for a programmable number of clocks, so the mux output `z` carries the byte serially. It replaces hand-driven stimulus with a reusable byte-to-serial front end.

## Interface
- `HOLD_CYCLES`, 4, clocks each `sel` value is held; legal range 1..256.
- `MSB_FIRST`, 0, selects the sel order:
  - 0: sel runs 0→7.
  - 1: sel runs 7→0.
- `clk` in 1, the single clock; all state updates on the rising edge.
- `rst` in 1, synchronous, active-high reset.
- `in_valid` in 1, producer has a byte on `in_data`.
- `in_data` in 8, byte to serialize.
- `in_ready` out 1, block can accept a byte this cycle.
- `a` out 8, mux data input (registered).
- `sel` out 3, mux select (registered).
- `bit_valid` out 1, high while `a`/`sel` describe a live frame bit.
- `frame_start` out 1, one-cycle pulse on the first cycle of a frame.
- `frame_done` out 1, one-cycle pulse on the last cycle of a frame.
- `busy` out 1, high in RUN.

## Operation
- State machine: IDLE, RUN.
- Internal registers:
  - hold counter `hcnt`, width max(1, clog2(HOLD_CYCLES)).
  - bit counter `bcnt`, 3 bits, counts 0..7 regardless of order.
  - `sel` = `bcnt` if MSB_FIRST=0, else 7−`bcnt`.
- Reset values: state=IDLE, `a`=8'h00, `sel`=3'b000, `hcnt`=0, `bcnt`=0.
- Outputs after reset: `in_ready`=1; `bit_valid`, `frame_start`, `frame_done`, `busy` all 0.
- Define `last` = RUN && `bcnt`==7 && `hcnt`==HOLD_CYCLES−1.
- `in_ready` = IDLE || `last`.
- Accept = `in_valid` && `in_ready`. On accept:
  - `a` ← `in_data`.
  - `bcnt` ← 0, `hcnt` ← 0.
  - state ← RUN.
- IDLE, no accept: all registers hold. `a`/`sel` keep their last values; `bit_valid`=0.
- RUN, not `last`:
  - `hcnt` increments.
  - When `hcnt`==HOLD_CYCLES−1, `hcnt` wraps to 0 and `bcnt` increments.
- RUN, `last`:
  - With accept: immediate reload with no gap, state stays RUN.
  - Without accept: state ← IDLE; `a`, `sel`, `bcnt` hold.
- `in_valid` is ignored while `in_ready`=0. The producer must hold `in_data` stable until accepted.
- `bit_valid` = `busy` = (state==RUN).
- `frame_start` = RUN && `bcnt`==0 && `hcnt`==0.
- `frame_done` = `last`.
- `rst` overrides everything, including mid-frame. The in-flight byte is discarded and no `frame_done` is issued for it.

## Timing
- Accept on edge k:
  - From cycle k+1: `a`=byte, `sel`=first index, `bit_valid`=1, `frame_start`=1.
- Each `sel` value is held exactly HOLD_CYCLES cycles. A frame lasts 8×HOLD_CYCLES cycles.
- `frame_done` is high in cycle k+8×HOLD_CYCLES.
- Back-to-back: a byte accepted in the `frame_done` cycle starts the next frame in the following cycle.
  - Sustained throughput is 1 byte per 8×HOLD_CYCLES clocks.
- HOLD_CYCLES=1: `hcnt` is constant 0; `sel` changes every cycle.
- `rst` asserted in cycle r: outputs show reset values from cycle r+1.

## Test plan
- Reset values:
  - Stimulus: assert `rst` 2 cycles with `in_valid`=1.
  - Response: `a`=0, `sel`=0, `in_ready`=1, `bit_valid`/`busy`/`frame_start`/`frame_done`=0; nothing accepted.
- Single frame, LSB-first:
  - Stimulus: HOLD_CYCLES=4, MSB_FIRST=0, send 8'b00001111.
  - Response:
    - `sel` = 0,1,…,7, 4 cycles each.
    - Mux `z` = 1,1,1,1,0,0,0,0.
    - `frame_done` in the 32nd cycle.
    - Return to IDLE, `in_ready`=1.
- MSB-first order:
  - Stimulus: MSB_FIRST=1, send 8'b11001111.
  - Response: `sel` = 7→0; `z` = 1,1,0,0,1,1,1,1.
- Back-to-back frames:
  - Stimulus: keep `in_valid`=1 with 8'h3C then 8'hF0.
  - Response:
    - Second byte accepted exactly in the `frame_done` cycle.
    - `frame_start` the next cycle; `bit_valid` never drops between frames.
    - Mid-frame `in_ready`=0.
- Reset mid-frame:
  - Stimulus: `rst` at bit 3 of 8'hFF.
  - Response: next cycle IDLE, `a`=0, `sel`=0, no `frame_done`. A new byte 8'h6F then runs a full frame.
- HOLD_CYCLES=1:
  - Stimulus: send 8'h4F.
  - Response: `sel` changes every cycle; `frame_done` in cycle 8 after acceptance.
